alu_serial_exec: RTL and testbench

Multi-cycle execute unit that consumes the 4-bit ALU operation code produced by the ALU control decoder, together with two operands, and performs the operation CHUNK bits per cycle. A carry chain runs across chunks. It sits in the execute stage of the multi-cycle datapath, behind a valid/ready handshake on each side. The design is sized for a small area footprint rather than throughput.

---
 rtl/alu_serial_exec.sv | 126 ++++++++++++
 tb/tb_alu_serial_exec.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_exec.sv
// Chunk-serial AND/OR/ADD/SUB execute unit. Processes CHUNK bits per beat, LSB chunk first,
// with a registered carry chain between beats and valid/ready handshakes on both sides.
module alu_serial_exec #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             illegal
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  op_a, op_b;
    logic [3:0]        op_code;
    logic [CW-1:0]     cnt;
    logic              carry;
    logic              accept, last_beat, is_arith;
    logic [CHUNK-1:0]  a_k, b_k, b_eff, chunk_res;
    logic [CHUNK:0]    sum;
    logic [WIDTH-1:0]  result_next;

    function automatic logic code_legal(input logic [3:0] code);
        return (code == OP_AND) || (code == OP_OR) || (code == OP_ADD) || (code == OP_SUB);
    endfunction

    assign in_ready  = (state == IDLE) && !reset;
    assign accept    = in_ready && in_valid;
    assign last_beat = (cnt == CW'(N - 1));
    assign is_arith  = (op_code == OP_ADD) || (op_code == OP_SUB);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (last_beat) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One chunk per beat; SUB is A + ~B with the carry preset to 1 at accept.
    always_comb begin
        a_k       = op_a[int'(cnt)*CHUNK +: CHUNK];
        b_k       = op_b[int'(cnt)*CHUNK +: CHUNK];
        b_eff     = (op_code == OP_SUB) ? ~b_k : b_k;
        sum       = {1'b0, a_k} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry};
        chunk_res = '0;
        case (op_code)
            OP_AND:         chunk_res = a_k & b_k;
            OP_OR:          chunk_res = a_k | b_k;
            OP_ADD, OP_SUB: chunk_res = sum[CHUNK-1:0];
            default:        chunk_res = '0;
        endcase
        result_next = result;
        result_next[int'(cnt)*CHUNK +: CHUNK] = chunk_res;
    end

    // Operands are only consumed in BUSY, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a    <= a;
            op_b    <= b;
            op_code <= ALU_control;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry_out <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        result <= '0;
                        carry  <= (ALU_control == OP_SUB);
                    end
                end
                BUSY: begin
                    result <= result_next;
                    carry  <= sum[CHUNK];
                    cnt    <= cnt + 1'b1;
                    if (last_beat) begin
                        zero      <= (result_next == '0);
                        carry_out <= is_arith ? sum[CHUNK] : 1'b0;
                        illegal   <= !code_legal(op_code);
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_exec.sv
// Self-checking bench for alu_serial_exec: table of vectors through a scoreboard queue,
// plus hand-written backpressure and mid-operation reset sequences.
module tb_alu_serial_exec;

    localparam int W = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    ALU_control;
    logic [W-1:0]  a, b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          zero, carry_out, illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]   code;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         il;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    alu_serial_exec #(.WIDTH(W), .CHUNK(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALU_control(ALU_control), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero),
        .carry_out(carry_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] code, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [W-1:0] res, input logic z, input logic c, input logic il);
        vec_t v;
        v.code = code; v.a = x; v.b = y; v.res = res; v.z = z; v.c = c; v.il = il;
        return v;
    endfunction

    // Reference model: full-width arithmetic, independent of chunking.
    function automatic vec_t model(input logic [3:0] code, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        if (code == 4'b0010) s = {1'b0, x} + {1'b0, y};
        else                 s = {1'b0, x} + {1'b0, ~y} + 65'd1;
        return mk(code, x, y, s[W-1:0], s[W-1:0] == '0, s[W], 1'b0);
    endfunction

    task automatic start(input vec_t v);
        @(negedge clk);
        ALU_control = v.code; a = v.a; b = v.b; in_valid = 1'b1;
        chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
        sb.push_back(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; ALU_control = 4'(($urandom));
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL out_valid_timeout actual=0 required=1");
        end
    endtask

    task automatic check_out();
        vec_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        e = sb.pop_front();
        chk("result",    result, e.res);
        chk("zero",      {63'd0, zero}, {63'd0, e.z});
        chk("carry_out", {63'd0, carry_out}, {63'd0, e.c});
        chk("illegal",   {63'd0, illegal}, {63'd0, e.il});
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("out_valid_after_hs", {63'd0, out_valid}, 64'd0);
        chk("in_ready_after_hs",  {63'd0, in_ready}, 64'd1);
        out_ready = 1'b0;
    endtask

    task automatic run(input vec_t v);
        int lat;
        start(v);
        wait_out(lat);
        chk("latency", 64'(lat), 64'd4);
        check_out();
        handshake();
    endtask

    initial begin
        int lat;
        logic seen;

        tbl.push_back(mk(4'b0010, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0110, 64'd5, 64'd5, 64'd0, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0000, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0001, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hFFF0_FFF0_FFF0_FFF0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(4'b0111, 64'h1234, 64'h1234, 64'd0, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b1, 1'b0));
        tbl.push_back(mk(4'b0001, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(model(4'b0010, {$urandom, $urandom}, {$urandom, $urandom}));
            tbl.push_back(model(4'b0110, {$urandom, $urandom}, {$urandom, $urandom}));
        end

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ALU_control = 4'b0000; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result",    result, 64'd0);
        chk("rst_flags",     {61'd0, zero, carry_out, illegal}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) run(tbl[i]);

        // Backpressure: hold the result for three cycles with a competing request present.
        start(mk(4'b0010, 64'd7, 64'd8, 64'd15, 1'b0, 1'b0, 1'b0));
        wait_out(lat);
        chk("bp_latency", 64'(lat), 64'd4);
        check_out();
        @(negedge clk);
        in_valid = 1'b1; ALU_control = 4'b0110; a = 64'd1; b = 64'd2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_in_ready",  {63'd0, in_ready}, 64'd0);
            chk("bp_result",    result, 64'd15);
            chk("bp_flags",     {61'd0, zero, carry_out, illegal}, 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
        chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("bp_not_queued", {63'd0, seen}, 64'd0);

        // Reset during the second BUSY cycle discards the operation.
        start(model(4'b0110, 64'd100, 64'd1));
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_in_ready",  {63'd0, in_ready}, 64'd0);
        chk("mid_rst_result",    result, 64'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_result", {63'd0, seen}, 64'd0);
        chk("mid_rst_in_ready_after", {63'd0, in_ready}, 64'd1);

        run(mk(4'b0010, 64'd2, 64'd3, 64'd5, 1'b0, 1'b0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
